// File: rtl/cache_line_sweeper.sv
// cache_line_sweeper
// ------------------
// Sequencer for one cache bank's tag store. After reset it walks every line
// issuing `init` so all tags start cleared. On a flush request it waits for the
// bank pipeline to empty, walks the lines issuing `flush` commands, waits for
// any resulting writebacks to drain, and then pulses `flush_req_ready`.
// In writeback mode every (line, way) pair gets its own flush command, with way
// as the inner loop. In the other mode one command covers all ways of a line.
//
// Optional feature (macro CACHE_SWEEPER_PERF_EN):
//   adds perf_flush_cycles, a saturating 32-bit count of cycles spent flushing
//   (DRAIN, FLUSH, WAIT, DONE). It is cleared only by reset.
//
// Ports:
//   clk               clock
//   reset             asynchronous, active-high reset
//   flush_req_valid   flush request, held high until accepted
//   flush_req_ready   one-cycle pulse when the flush has fully completed
//   bank_empty        no requests in flight in the bank pipeline/MSHR
//   stall             bank stall; the current command is held, not consumed
//   init              init command to the tag store this cycle
//   flush             flush command to the tag store this cycle
//   line_idx          line index of the current command
//   way_idx           way of the current command (0 when WRITEBACK=0)
//   busy              sweeper active; the bank must not accept core requests
//   perf_flush_cycles (CACHE_SWEEPER_PERF_EN only) flush cycle counter
module cache_line_sweeper #(
    parameter int unsigned CACHE_SIZE = 1024,
    parameter int unsigned LINE_SIZE  = 16,
    parameter int unsigned NUM_BANKS  = 1,
    parameter int unsigned NUM_WAYS   = 1,
    parameter int unsigned WRITEBACK  = 0,
    localparam int unsigned LINES = CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS),
    localparam int unsigned LSB   = (LINES > 2) ? $clog2(LINES) : 1,
    localparam int unsigned WSB   = (NUM_WAYS > 2) ? $clog2(NUM_WAYS) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush_req_valid,
    output logic           flush_req_ready,
    input  logic           bank_empty,
    input  logic           stall,
    output logic           init,
    output logic           flush,
    output logic [LSB-1:0] line_idx,
    output logic [WSB-1:0] way_idx,
    output logic           busy
`ifdef CACHE_SWEEPER_PERF_EN
    ,
    output logic [31:0]    perf_flush_cycles
`endif
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_DRAIN,
        S_FLUSH,
        S_WAIT,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [LSB-1:0] line_q, line_d;
    logic [WSB-1:0] way_q, way_d;

    logic last_line;
    logic last_way;

    // Explicit terminal compares so the counters wrap to 0 at LINES-1 and
    // NUM_WAYS-1 even when those are not powers of two.
    assign last_line = (line_q == LSB'(LINES - 1));
    assign last_way  = (way_q == WSB'(NUM_WAYS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            line_q  <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            way_q   <= way_d;
        end
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        way_d   = way_q;
        unique case (state_q)
            S_INIT: begin
                if (!stall) begin
                    if (last_line) begin
                        line_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        line_d = line_q + 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (flush_req_valid) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bank_empty) begin
                    line_d  = '0;
                    way_d   = '0;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // bank_empty is deliberately not looked at here; only WAIT
                // cares about writebacks generated by the flush walk.
                if (!stall) begin
                    if ((WRITEBACK != 0) && !last_way) begin
                        way_d = way_q + 1'b1;
                    end else begin
                        way_d = '0;
                        if (last_line) begin
                            line_d  = '0;
                            state_d = S_WAIT;
                        end else begin
                            line_d = line_q + 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (bank_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
                line_d  = '0;
                way_d   = '0;
            end
        endcase
    end

    // All outputs are decoded from registers only.
    assign init            = (state_q == S_INIT);
    assign flush           = (state_q == S_FLUSH);
    assign busy            = (state_q != S_IDLE);
    assign flush_req_ready = (state_q == S_DONE);
    assign line_idx        = line_q;
    assign way_idx         = way_q;

`ifdef CACHE_SWEEPER_PERF_EN
    logic [31:0] perf_q, perf_d;
    logic        flushing;

    assign flushing = (state_q == S_DRAIN) || (state_q == S_FLUSH) ||
                      (state_q == S_WAIT)  || (state_q == S_DONE);

    always_comb begin
        perf_d = perf_q;
        if (flushing && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_flush_cycles = perf_q;
`endif

endmodule

// File: tb/tb_cache_line_sweeper.sv
// Bench for cache_line_sweeper: two instances (WRITEBACK=0 and WRITEBACK=1),
// 1024-byte cache, 16-byte lines, 4 ways -> 16 lines. Directed scenarios build
// the expected per-cycle output trace from the sweep rules (loops over lines and
// ways). A single negedge process compares both instances every cycle.
// Literal checks pin latencies, command counts and ready counts.
module tb_cache_line_sweeper;

    localparam int L = 16;
    localparam int W = 4;

    typedef struct packed {
        logic       init;
        logic       flush;
        logic       busy;
        logic       rdy;
        logic [3:0] line;
        logic [1:0] way;
    } out_t;

    localparam out_t IDL = '0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic v [2];
    logic be [2];
    logic st [2];

    logic       init_o [2];
    logic       flush_o [2];
    logic       busy_o [2];
    logic       rdy_o [2];
    logic [3:0] line_o [2];
    logic [1:0] way_o [2];
`ifdef CACHE_SWEEPER_PERF_EN
    logic [31:0] perf_o [2];
`endif

    always #5 clk = ~clk;

    cache_line_sweeper #(
        .CACHE_SIZE(1024), .LINE_SIZE(16), .NUM_BANKS(1), .NUM_WAYS(4), .WRITEBACK(0)
    ) dut0 (
        .clk(clk), .reset(reset), .flush_req_valid(v[0]), .flush_req_ready(rdy_o[0]),
        .bank_empty(be[0]), .stall(st[0]), .init(init_o[0]), .flush(flush_o[0]),
        .line_idx(line_o[0]), .way_idx(way_o[0]), .busy(busy_o[0])
`ifdef CACHE_SWEEPER_PERF_EN
        , .perf_flush_cycles(perf_o[0])
`endif
    );

    cache_line_sweeper #(
        .CACHE_SIZE(1024), .LINE_SIZE(16), .NUM_BANKS(1), .NUM_WAYS(4), .WRITEBACK(1)
    ) dut1 (
        .clk(clk), .reset(reset), .flush_req_valid(v[1]), .flush_req_ready(rdy_o[1]),
        .bank_empty(be[1]), .stall(st[1]), .init(init_o[1]), .flush(flush_o[1]),
        .line_idx(line_o[1]), .way_idx(way_o[1]), .busy(busy_o[1])
`ifdef CACHE_SWEEPER_PERF_EN
        , .perf_flush_cycles(perf_o[1])
`endif
    );

    int   checks = 0;
    int   failures = 0;
    int   cyc_n = 0;
    bit   chk_en = 1'b0;
    out_t exp_o [2];
    int   rdy_at [2];
    int   rdy_cnt [2];
    int   flush_cnt [2];

    function automatic out_t mk(input bit i, input bit f, input bit b, input bit r,
                                input int l, input int w);
        out_t o;
        o.init  = i;
        o.flush = f;
        o.busy  = b;
        o.rdy   = r;
        o.line  = 4'(l);
        o.way   = 2'(w);
        return o;
    endfunction

    // Init command, flush command, busy-without-command, done pulse.
    function automatic out_t e_init(input int l);
        return mk(1, 0, 1, 0, l, 0);
    endfunction
    function automatic out_t e_flush(input int l, input int w);
        return mk(0, 1, 1, 0, l, w);
    endfunction
    function automatic out_t e_busy();
        return mk(0, 0, 1, 0, 0, 0);
    endfunction
    function automatic out_t e_done();
        return mk(0, 0, 1, 1, 0, 0);
    endfunction

    // Compare process: every checked cycle, both instances against the trace.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                out_t got;
                got = mk(init_o[d], flush_o[d], busy_o[d], rdy_o[d], int'(line_o[d]), int'(way_o[d]));
                checks++;
                if (got !== exp_o[d]) begin
                    failures++;
                    $display("FAIL dut%0d_outputs cyc=%0d got init=%b flush=%b busy=%b rdy=%b line=%0d way=%0d exp init=%b flush=%b busy=%b rdy=%b line=%0d way=%0d",
                             d, cyc_n, got.init, got.flush, got.busy, got.rdy, got.line, got.way,
                             exp_o[d].init, exp_o[d].flush, exp_o[d].busy, exp_o[d].rdy,
                             exp_o[d].line, exp_o[d].way);
                end
                if (rdy_o[d] === 1'b1) begin
                    rdy_at[d] = cyc_n;
                    rdy_cnt[d]++;
                end
                if (flush_o[d] === 1'b1) flush_cnt[d]++;
            end
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, expv);
        end
    endtask

    // One cycle: inputs are already set for this cycle; publish expectations.
    task automatic cyc2(input out_t e0, input out_t e1);
        exp_o[0] = e0;
        exp_o[1] = e1;
        chk_en   = 1'b1;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic cycd(input int d, input out_t e);
        if (d == 0) cyc2(e, IDL);
        else        cyc2(IDL, e);
    endtask

    task automatic clr_stats();
        for (int d = 0; d < 2; d++) begin
            rdy_at[d] = -1;
            rdy_cnt[d] = 0;
            flush_cnt[d] = 0;
        end
    endtask

    // Reset pulse followed by the init walk (optionally stalled or cut short).
    task automatic do_reset(input bit v_init, input int stall_line, input int stall_len,
                            input int abort_line);
        for (int d = 0; d < 2; d++) begin
            v[d] = 1'b0;
            be[d] = 1'b1;
            st[d] = 1'b0;
        end
        reset = 1'b1;
        cyc2(e_init(0), e_init(0));
`ifdef CACHE_SWEEPER_PERF_EN
        chk("perf0_after_reset", int'(perf_o[0]), 0);
        chk("perf1_after_reset", int'(perf_o[1]), 0);
`endif
        reset = 1'b0;
        v[0] = v_init;
        for (int l = 0; l < L; l++) begin
            if (l == abort_line) return;
            if (l == stall_line) begin
                st[0] = 1'b1;
                st[1] = 1'b1;
                repeat (stall_len) cyc2(e_init(l), e_init(l));
                st[0] = 1'b0;
                st[1] = 1'b0;
            end
            cyc2(e_init(l), e_init(l));
        end
    endtask

    // A flush on instance d (d=1 is the writeback instance). First cycle is the
    // IDLE cycle in which the request is seen.
    task automatic run_flush(input int d, input int stall_line, input int stall_len,
                             input int drain_low, input int wait_low,
                             input int abort_line, input bit be_glitch, output int req_cyc);
        int nw;
        nw = (d == 1) ? W : 1;
        v[d]  = 1'b1;
        be[d] = 1'b1;
        req_cyc = cyc_n;
        cycd(d, IDL);
        be[d] = 1'b0;
        repeat (drain_low) cycd(d, e_busy());
        be[d] = 1'b1;
        cycd(d, e_busy());
        for (int l = 0; l < L; l++) begin
            for (int w = 0; w < nw; w++) begin
                be[d] = (be_glitch && l >= 4 && l < 8) ? 1'b0 : 1'b1;
                if (l == abort_line && w == 0) begin
                    cycd(d, e_flush(l, w));
                    return;
                end
                if (l == stall_line && w == 0) begin
                    st[d] = 1'b1;
                    repeat (stall_len) cycd(d, e_flush(l, w));
                    st[d] = 1'b0;
                end
                cycd(d, e_flush(l, w));
            end
        end
        be[d] = 1'b0;
        repeat (wait_low) cycd(d, e_busy());
        be[d] = 1'b1;
        cycd(d, e_busy());
        cycd(d, e_done());
    endtask

    initial begin
        int req;
        int req2;
        for (int d = 0; d < 2; d++) begin
            v[d] = 1'b0;
            be[d] = 1'b1;
            st[d] = 1'b0;
        end
        clr_stats();
        @(posedge clk);
        #1;

        // Reset and clean init walk, then idle.
        do_reset(1'b0, -1, 0, -1);
        cyc2(IDL, IDL);
        cyc2(IDL, IDL);

        // Plain WRITEBACK=0 flush, then valid left high after DONE: a second
        // flush starts immediately, with bank_empty dropping mid-walk.
        clr_stats();
        run_flush(0, -1, 0, 0, 0, -1, 1'b0, req);
        chk("wb0_latency", rdy_at[0] - req, 19);
        chk("wb0_flush_cmds", flush_cnt[0], 16);
        run_flush(0, -1, 0, 0, 0, -1, 1'b1, req2);
        v[0] = 1'b0;
        cyc2(IDL, IDL);
        chk("wb0_back_to_back_latency", rdy_at[0] - req2, 19);
        chk("wb0_ready_pulses", rdy_cnt[0], 2);

        // WRITEBACK=1 flush, bank_empty low 5 cycles in WAIT.
        clr_stats();
        run_flush(1, -1, 0, 0, 5, -1, 1'b0, req);
        v[1] = 1'b0;
        cyc2(IDL, IDL);
        chk("wb1_wait5_latency", rdy_at[1] - req, 72);
        chk("wb1_flush_cmds", flush_cnt[1], 64);
        chk("wb1_ready_pulses", rdy_cnt[1], 1);

        // WRITEBACK=1 with drain delay and a stall on the last line.
        clr_stats();
        run_flush(1, 15, 2, 2, 0, -1, 1'b0, req);
        v[1] = 1'b0;
        cyc2(IDL, IDL);
        chk("wb1_stall_drain_latency", rdy_at[1] - req, 71);

        // Stall 3 cycles at line 7: line 7 shown for 4 cycles, latency +3.
        clr_stats();
        run_flush(0, 7, 3, 0, 0, -1, 1'b0, req);
        v[0] = 1'b0;
        cyc2(IDL, IDL);
        chk("wb0_stall_latency", rdy_at[0] - req, 22);
        chk("wb0_stall_flush_cycles", flush_cnt[0], 19);

        // Request raised at reset release: served after init, one ready.
        clr_stats();
        do_reset(1'b1, -1, 0, -1);
        chk("no_ready_during_init", rdy_cnt[0], 0);
        run_flush(0, -1, 0, 0, 0, -1, 1'b0, req);
        v[0] = 1'b0;
        cyc2(IDL, IDL);
        chk("init_req_latency", rdy_at[0] - req, 19);
        chk("init_req_ready_pulses", rdy_cnt[0], 1);
`ifdef CACHE_SWEEPER_PERF_EN
        chk("perf0_one_flush", int'(perf_o[0]), 19);
        chk("perf1_untouched", int'(perf_o[1]), 0);
`endif

        // Reset while flushing line 9, and reset mid-init; then stalled init.
        clr_stats();
        run_flush(0, -1, 0, 0, 0, 9, 1'b0, req);
        do_reset(1'b0, -1, 0, 5);
        do_reset(1'b0, 5, 2, -1);
        cyc2(IDL, IDL);
        chk("aborted_flush_no_ready", rdy_cnt[0], 0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
